// File: rtl/sys_cmd_ctrl_if.sv
// sys_cmd_ctrl_if: byte-stream, register-file, ALU and TX FIFO signals around the command controller
// master: controller side (drives strobes, addr/data, tx bytes, status)
// slave : peer side (drives rx bytes, read data, ALU result, fifo_full)
interface sys_cmd_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int FW = 4,
  parameter int RES_BYTES = 2
);
  logic [DW-1:0] rx_p_data;
  logic rx_d_valid;
  logic [DW-1:0] rd_data;
  logic rd_d_valid;
  logic [RES_BYTES*DW-1:0] alu_out;
  logic alu_out_valid;
  logic fifo_full;
  logic wr_en;
  logic rd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic alu_en;
  logic [FW-1:0] alu_func;
  logic clk_gate_en;
  logic clk_div_en;
  logic [DW-1:0] tx_p_data;
  logic tx_d_valid;
  logic frame_err;
  logic busy;
  modport master (
    input rx_p_data, rx_d_valid, rd_data, rd_d_valid, alu_out, alu_out_valid, fifo_full,
    output wr_en, rd_en, addr, wr_data, alu_en, alu_func, clk_gate_en, clk_div_en,
    output tx_p_data, tx_d_valid, frame_err, busy
  );
  modport slave (
    output rx_p_data, rx_d_valid, rd_data, rd_d_valid, alu_out, alu_out_valid, fifo_full,
    input wr_en, rd_en, addr, wr_data, alu_en, alu_func, clk_gate_en, clk_div_en,
    input tx_p_data, tx_d_valid, frame_err, busy
  );
endinterface

// File: rtl/sys_cmd_ctrl.sv
// sys_cmd_ctrl: decodes UART command frames into register/ALU operations and streams results to TX
// clk, rst (async, active-low); bus (master modport): rx bytes in, register strobes, ALU control,
// TX FIFO bytes out, frame_err pulse, busy status. Every bus output is registered.
module sys_cmd_ctrl #(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int FW = 4,
  parameter int RES_BYTES = 2,
  parameter int OPA_ADDR = 0,
  parameter int OPB_ADDR = 1,
  parameter int TO_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  sys_cmd_ctrl_if.master bus
);
  localparam int CW = $clog2(TO_CYCLES + 1);
  localparam logic [DW-1:0] OP_RW = DW'(8'hAA);
  localparam logic [DW-1:0] OP_RR = DW'(8'hBB);
  localparam logic [DW-1:0] OP_ALU = DW'(8'hCC);
  localparam logic [DW-1:0] OP_FN = DW'(8'hDD);
  typedef enum logic [3:0] {
    IDLE, RW_ADDR, RW_DATA, RR_ADDR, RR_WAIT, ALU_A, ALU_B, ALU_FUNC, ALU_WAIT, TX
  } state_t;
  state_t state, nxt;
  logic [RES_BYTES*DW-1:0] res;
  logic [2:0] nbytes;
  logic [1:0] k;
  logic [CW-1:0] cnt;
  logic rx_st, timed, ev, tmo, ovr, bad_op, send, last, alu_op;
  logic d_wr_en, d_rd_en, d_alu_en, d_gate, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wr_data, d_tx_data;
  logic [FW-1:0] d_alu_func;
  assign rx_st = state inside {RW_ADDR, RW_DATA, RR_ADDR, ALU_A, ALU_B, ALU_FUNC};
  assign timed = rx_st || state inside {RR_WAIT, ALU_WAIT};
  // any event that keeps the current frame alive; overrun bytes in wait states are not one
  assign ev = (rx_st && bus.rx_d_valid) || (state == RR_WAIT && bus.rd_d_valid) ||
              (state == ALU_WAIT && bus.alu_out_valid);
  assign tmo = timed && !ev && cnt == CW'(TO_CYCLES - 1);
  assign ovr = bus.rx_d_valid && state inside {RR_WAIT, ALU_WAIT, TX};
  assign alu_op = bus.rx_p_data == OP_ALU || bus.rx_p_data == OP_FN;
  assign bad_op = state == IDLE && bus.rx_d_valid &&
                  !(bus.rx_p_data inside {OP_RW, OP_RR, OP_ALU, OP_FN});
  assign send = state == TX && !bus.fifo_full;
  assign last = {1'b0, k} == nbytes - 3'd1;
  assign bus.clk_div_en = 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      res <= '0;
      nbytes <= '0;
      k <= '0;
      cnt <= '0;
      bus.wr_en <= 1'b0;
      bus.rd_en <= 1'b0;
      bus.addr <= '0;
      bus.wr_data <= '0;
      bus.alu_en <= 1'b0;
      bus.alu_func <= '0;
      bus.clk_gate_en <= 1'b0;
      bus.tx_p_data <= '0;
      bus.tx_d_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      state <= nxt;
      res <= state == RR_WAIT && bus.rd_d_valid ? (RES_BYTES*DW)'(bus.rd_data) :
             state == ALU_WAIT && bus.alu_out_valid ? bus.alu_out : res;
      nbytes <= state == RR_WAIT && bus.rd_d_valid ? 3'd1 :
                state == ALU_WAIT && bus.alu_out_valid ? 3'(RES_BYTES) : nbytes;
      k <= send ? k + 2'd1 : state == TX ? k : 2'd0;
      cnt <= !timed || ev || tmo ? '0 : cnt + CW'(1);
      bus.wr_en <= d_wr_en;
      bus.rd_en <= d_rd_en;
      bus.addr <= d_addr;
      bus.wr_data <= d_wr_data;
      bus.alu_en <= d_alu_en;
      bus.alu_func <= d_alu_func;
      bus.clk_gate_en <= d_gate;
      bus.tx_p_data <= d_tx_data;
      bus.tx_d_valid <= send;
      bus.frame_err <= d_err;
      bus.busy <= nxt != IDLE;
    end
  always_comb begin
    nxt = state;
    if (tmo) nxt = IDLE;
    else
      case (state)
        IDLE: if (bus.rx_d_valid) nxt = bus.rx_p_data == OP_RW ? RW_ADDR :
                                        bus.rx_p_data == OP_RR ? RR_ADDR :
                                        bus.rx_p_data == OP_ALU ? ALU_A :
                                        bus.rx_p_data == OP_FN ? ALU_FUNC : IDLE;
        RW_ADDR: if (bus.rx_d_valid) nxt = RW_DATA;
        RW_DATA: if (bus.rx_d_valid) nxt = IDLE;
        RR_ADDR: if (bus.rx_d_valid) nxt = RR_WAIT;
        RR_WAIT: if (bus.rd_d_valid) nxt = TX;
        ALU_A: if (bus.rx_d_valid) nxt = ALU_B;
        ALU_B: if (bus.rx_d_valid) nxt = ALU_FUNC;
        ALU_FUNC: if (bus.rx_d_valid) nxt = ALU_WAIT;
        ALU_WAIT: if (bus.alu_out_valid) nxt = TX;
        TX: if (send && last) nxt = IDLE;
        default: nxt = IDLE;
      endcase
  end
  always_comb begin
    d_wr_en = bus.rx_d_valid && state inside {RW_DATA, ALU_A, ALU_B};
    d_rd_en = bus.rx_d_valid && state == RR_ADDR;
    d_alu_en = bus.rx_d_valid && state == ALU_FUNC;
    d_addr = !bus.rx_d_valid ? bus.addr :
             state inside {RW_ADDR, RR_ADDR} ? bus.rx_p_data[AW-1:0] :
             state == ALU_A ? AW'(OPA_ADDR) :
             state == ALU_B ? AW'(OPB_ADDR) : bus.addr;
    d_wr_data = d_wr_en ? bus.rx_p_data : bus.wr_data;
    d_alu_func = d_alu_en ? bus.rx_p_data[FW-1:0] : bus.alu_func;
    d_gate = state == IDLE && bus.rx_d_valid && alu_op ? 1'b1 :
             tmo || (state == ALU_WAIT && bus.alu_out_valid) ? 1'b0 : bus.clk_gate_en;
    d_err = bad_op || tmo || ovr;
    d_tx_data = send ? res[k*DW +: DW] : bus.tx_p_data;
  end
endmodule
